// File: rtl/fec_pkg.sv
// Shared types and helpers for the streaming 2D-parity FEC encoder.
package fec_pkg;

  localparam int unsigned FEC_MAX_W = 64;

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } fec_enc_state_e;

  // Parity of a zero-extended vector; zero padding leaves the XOR-reduce unchanged.
  function automatic logic fec_parity(input logic [FEC_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/fec_stream_encoder_if.sv
// Row-in / beat-out stream bundle of the FEC encoder, plus block status.
interface fec_stream_encoder_if #(
  parameter int unsigned WIDTH = 4
);
  logic             parity_odd;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_row_par;
  logic             out_is_par;
  logic             busy;
  logic             blk_done;

  modport master (
    output parity_odd, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row_par, out_is_par, busy, blk_done
  );

  modport slave (
    input  parity_odd, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row_par, out_is_par, busy, blk_done
  );
endinterface

// File: rtl/fec_par_acc.sv
// Column-parity accumulator with clear and even/odd inversion.
// Corner bit exists only when FEC_CORNER_PARITY_EN is defined.
module fec_par_acc
  import fec_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] col_par_c_o,
  output logic             corner_c_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign col_par_c_o = acc_q ^ {WIDTH{mode_i}};

`ifdef FEC_CORNER_PARITY_EN
  assign corner_c_o = fec_parity(FEC_MAX_W'(acc_q), mode_i);
`else
  assign corner_c_o = 1'b0;
`endif

endmodule

// File: rtl/fec_stream_encoder.sv
// Streaming 2D-parity FEC encoder: forwards rows with row parity, then one column-parity beat.
// Optional corner parity on the parity beat: define FEC_CORNER_PARITY_EN.
module fec_stream_encoder
  import fec_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  fec_stream_encoder_if.slave bus
);

  localparam int unsigned       CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_ROW = CNT_W'(DEPTH - 1);

  fec_enc_state_e   state_q;
  logic [CNT_W-1:0] row_cnt_q;
  logic             mode_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_row_par_q;
  logic             out_is_par_q;
  logic             busy_q;
  logic             blk_done_q;

  logic             out_free_c;
  logic             in_fire_c;
  logic             out_fire_c;
  logic             par_load_c;
  logic             first_row_c;
  logic             row_mode_c;
  logic [WIDTH-1:0] col_par_c;
  logic             corner_c;

  assign out_free_c  = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (state_q == S_DATA) && out_free_c;
  assign in_fire_c   = bus.in_valid && bus.in_ready;
  assign out_fire_c  = out_valid_q && bus.out_ready;
  assign par_load_c  = (state_q == S_PAR) && out_free_c;
  assign first_row_c = (row_cnt_q == '0);
  // The first row of a block must already use the mode it is about to latch.
  assign row_mode_c  = first_row_c ? bus.parity_odd : mode_q;

  fec_par_acc #(
    .WIDTH(WIDTH)
  ) u_par_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (par_load_c),
    .en_i       (in_fire_c),
    .mode_i     (mode_q),
    .data_i     (bus.in_data),
    .col_par_c_o(col_par_c),
    .corner_c_o (corner_c)
  );

  // FSM, row counter and output register; loads override the drain of a taken beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_DATA;
      row_cnt_q     <= '0;
      mode_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_row_par_q <= 1'b0;
      out_is_par_q  <= 1'b0;
      busy_q        <= 1'b0;
      blk_done_q    <= 1'b0;
    end else begin
      blk_done_q <= out_fire_c && out_is_par_q;

      if (out_fire_c) begin
        out_valid_q <= 1'b0;
        if (out_is_par_q) begin
          busy_q <= 1'b0;
        end
      end

      if (in_fire_c) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= bus.in_data;
        out_row_par_q <= fec_parity(FEC_MAX_W'(bus.in_data), row_mode_c);
        out_is_par_q  <= 1'b0;
        busy_q        <= 1'b1;
        if (first_row_c) begin
          mode_q <= bus.parity_odd;
        end
        if (row_cnt_q == LAST_ROW) begin
          row_cnt_q <= '0;
          state_q   <= S_PAR;
        end else begin
          row_cnt_q <= row_cnt_q + CNT_W'(1);
        end
      end

      if (par_load_c) begin
        out_valid_q   <= 1'b1;
        out_data_q    <= col_par_c;
        out_row_par_q <= corner_c;
        out_is_par_q  <= 1'b1;
        state_q       <= S_DATA;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_row_par = out_row_par_q;
  assign bus.out_is_par  = out_is_par_q;
  assign bus.busy        = busy_q;
  assign bus.blk_done    = blk_done_q;

endmodule

// File: tb/tb_fec_stream_encoder.sv
// Scoreboard bench for fec_stream_encoder: a 4x4 instance with directed blocks and an 8x3 instance with random rows.
module tb_fec_stream_encoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fec_stream_encoder_if #(.WIDTH(4)) if0 ();
  fec_stream_encoder_if #(.WIDTH(8)) if1 ();

  fec_stream_encoder #(.WIDTH(4), .DEPTH(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fec_stream_encoder #(.WIDTH(8), .DEPTH(3)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  typedef struct packed {
    logic       ip;
    logic       rp;
    logic [7:0] data;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;
  int    n_checks = 0;
  int    n_errors = 0;
  logic  done0_exp = 1'b0;
  logic  done1_exp = 1'b0;

  // model state for the 8x3 instance
  int         m1_cnt  = 0;
  logic [7:0] m1_col  = '0;
  logic       m1_mode = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic cx(input logic v);
`ifdef FEC_CORNER_PARITY_EN
    return v;
`else
    return v & 1'b0;
`endif
  endfunction

  // Monitors: sample late in the low phase, where inputs are settled for the coming edge.
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      q0.delete();
      done0_exp = 1'b0;
    end else begin
      chk("blk_done0", 32'(if0.blk_done), 32'(done0_exp));
      done0_exp = 1'b0;
      if (if0.out_valid && if0.out_ready) begin
        if (q0.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL beat0_unexpected: got %0h with empty queue", if0.out_data);
        end else begin
          e0 = q0.pop_front();
          chk("beat0", {if0.out_is_par, if0.out_row_par, 4'h0, if0.out_data}, {e0.ip, e0.rp, e0.data});
        end
        done0_exp = if0.out_is_par;
      end
    end
  end

  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      q1.delete();
      done1_exp = 1'b0;
    end else begin
      chk("blk_done1", 32'(if1.blk_done), 32'(done1_exp));
      done1_exp = 1'b0;
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL beat1_unexpected: got %0h with empty queue", if1.out_data);
        end else begin
          e1 = q1.pop_front();
          chk("beat1", {if1.out_is_par, if1.out_row_par, if1.out_data}, {e1.ip, e1.rp, e1.data});
        end
        done1_exp = if1.out_is_par;
      end
    end
  end

  // Drivers enter and leave at negedge+1.
  task automatic send0(input logic [3:0] d, input logic rp);
    bit acc;
    int t;
    acc = 1'b0; t = 0;
    if0.in_valid = 1'b1; if0.in_data = d;
    while (!acc && t < 50) begin
      #1; acc = if0.in_ready;
      @(posedge clk);
      if (acc) q0.push_back({1'b0, rp, 8'(d)});
      @(negedge clk); #1; t++;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send0_timeout: in_ready stayed 0, expected 1");
    end
    if0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [7:0] d, output int stalls);
    bit acc;
    int t;
    acc = 1'b0; t = 0;
    if1.in_valid = 1'b1; if1.in_data = d;
    while (!acc && t < 50) begin
      #1; acc = if1.in_ready;
      @(posedge clk);
      if (acc) begin
        if (m1_cnt == 0) m1_mode = if1.parity_odd;
        q1.push_back({1'b0, (^d) ^ m1_mode, d});
        m1_col = m1_col ^ d;
        m1_cnt++;
        if (m1_cnt == 3) begin
          q1.push_back({1'b1, cx((^m1_col) ^ m1_mode), m1_col ^ {8{m1_mode}}});
          m1_col = '0;
          m1_cnt = 0;
        end
      end
      @(negedge clk); #1; t++;
    end
    stalls = t - 1;
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL send1_timeout: in_ready stayed 0, expected 1");
    end
    if1.in_valid = 1'b0;
  endtask

  task automatic block0(input logic [3:0] r [4], input logic [3:0] rp, input logic [3:0] par,
                        input logic corner, input logic odd, input bit toggle);
    if0.parity_odd = odd;
    for (int i = 0; i < 4; i++) begin
      send0(r[i], rp[i]);
      if (toggle && i == 1) if0.parity_odd = !odd;
    end
    q0.push_back({1'b1, cx(corner), 8'(par)});
  endtask

  logic [3:0] rows_a [4];
  int         st;
  int         stalls_tot;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if0.in_valid = 1'b0; if0.in_data = '0; if0.parity_odd = 1'b0; if0.out_ready = 1'b1;
    if1.in_valid = 1'b0; if1.in_data = '0; if1.parity_odd = 1'b0; if1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("reset0_outs", {if0.out_valid, if0.out_is_par, if0.out_row_par, if0.busy, if0.blk_done, if0.out_data}, 32'h0);
    chk("reset1_outs", {if1.out_valid, if1.out_is_par, if1.out_row_par, if1.busy, if1.blk_done, if1.out_data}, 32'h0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_idle", 32'(if0.in_ready), 32'h1);
    @(negedge clk); #1;

    // even block: row parity 1,0,1,0; column 0xA; corner 0
    rows_a = '{4'h1, 4'h3, 4'h7, 4'hF};
    block0(rows_a, 4'b0101, 4'hA, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("busy_before_par_take", 32'(if0.busy), 32'h1);
    @(negedge clk); #1;
    chk("busy_fall_done_rise", {if0.busy, if0.blk_done}, 32'h1);

    // odd block: row parity 0,1,0,1; column 0x5; corner 1
    block0(rows_a, 4'b1010, 4'h5, 1'b1, 1'b1, 1'b0);
    // same, with parity_odd dropped after row 1: latched mode must win
    block0(rows_a, 4'b1010, 4'h5, 1'b1, 1'b1, 1'b1);

    // backpressure: rows 5,6,8,0 even -> rp 0,0,1,0, column 0xB, corner 1
    if0.parity_odd = 1'b0;
    send0(4'h5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if0.out_ready = 1'b0;
      #1;
      chk("bp_in_ready", 32'(if0.in_ready), 32'h0);
      chk("bp_hold", {if0.out_valid, if0.out_is_par, if0.out_row_par, if0.out_data}, {3'b100, 4'h5});
      @(negedge clk); #1;
    end
    if0.out_ready = 1'b1;
    send0(4'h6, 1'b0);
    send0(4'h8, 1'b1);
    send0(4'h0, 1'b0);
    q0.push_back({1'b1, cx(1'b1), 8'h0B});
    repeat (3) @(negedge clk);
    #1;

    // reset two rows into a block, then a clean block of 0x2s
    if0.parity_odd = 1'b0;
    send0(4'h1, 1'b1);
    send0(4'h3, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_outs", {if0.out_valid, if0.out_is_par, if0.out_row_par, if0.busy, if0.blk_done, if0.out_data}, 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(if0.in_ready), 32'h1);
    @(negedge clk); #1;
    rows_a = '{4'h2, 4'h2, 4'h2, 4'h2};
    block0(rows_a, 4'b1111, 4'h0, 1'b0, 1'b0, 1'b0);

    // back-to-back random blocks on the 8x3 instance
    stalls_tot = 0;
    for (int b = 0; b < 6; b++) begin
      if1.parity_odd = 1'($urandom_range(0, 1));
      for (int r = 0; r < 3; r++) begin
        send1(8'($urandom), st);
        stalls_tot += st;
      end
    end
    chk("b2b_in_ready_low_cycles", 32'(stalls_tot), 32'd5);

    repeat (6) @(negedge clk);
    #4;
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    chk("busy_idle", {if0.busy, if1.busy}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
